neureka_tcdm_port_sync: RTL and testbench
=========================================

NEUREKA_TCDM_PORT_SYNC -- requirements
Module: neureka_tcdm_port_sync

Interface
REQ-001 SHALL have parameter MP, default 4, number of 32-bit memory ports that one wide transaction is split across.
REQ-002 SHALL have parameter STALL_CW, default 16, width of the stall counter.
REQ-003 SHALL have ports clk_i (in, 1, the only clock) and rst_i (in, 1, reset); reset is asynchronous and active-high.
REQ-004 SHALL have port clear_i, in, 1: synchronous soft clear.
REQ-005 SHALL have wide-side inputs: req_i (1), add_i (32), wen_i (1, 1 = read), be_i (4*MP), data_i (32*MP).
REQ-006 SHALL have wide-side outputs: gnt_o (1), r_valid_o (1), r_data_o (32*MP).
REQ-007 SHALL have memory-side outputs: tcdm_req_o (MP), tcdm_add_o (MPx32), tcdm_wen_o (MP), tcdm_be_o (MPx4), tcdm_data_o (MPx32).
REQ-008 SHALL have memory-side inputs: tcdm_gnt_i (MP), tcdm_r_valid_i (MP), tcdm_r_data_i (MPx32).
REQ-009 SHALL have status outputs: busy_o (1), err_o (1, sticky), stall_cnt_o (STALL_CW).

Function
REQ-010 Port k SHALL carry tcdm_add_o[k] = add_i + 4*k (mod 2^32), be slice [4k+3:4k], data slice [32k+31:32k], and wen_i.
REQ-011 SHALL keep a granted mask done_q (MP bits): tcdm_req_o[k] = req_i & ~done_q[k], so a port is never re-requested after it is granted within the same wide transaction.
REQ-012 gnt_o SHALL be combinational: req_i & AND over k of (done_q[k] | tcdm_gnt_i[k]).
REQ-013 When gnt_o = 1, done_q SHALL clear to 0 at the next edge; otherwise done_q |= tcdm_req_o & tcdm_gnt_i.
REQ-014 FSM SHALL have two states. IDLE means done_q == 0. PARTIAL means done_q != 0.
REQ-015 FSM transitions: IDLE->PARTIAL on req_i & any grant & ~gnt_o; PARTIAL->IDLE on gnt_o; all other cases hold.
REQ-016 A wide transaction granted in a single cycle SHALL stay in IDLE.
REQ-017 busy_o SHALL equal (state == PARTIAL) | r_valid_o.
REQ-018 Per-port read data SHALL be captured into rbuf_q[k] whenever tcdm_r_valid_i[k] = 1.
REQ-019 r_valid_o SHALL assert exactly 1 cycle after gnt_o, for reads and writes, as a registered copy of gnt_o.
REQ-020 r_data_o slice k SHALL be tcdm_r_data_i[k] if tcdm_r_valid_i[k] = 1 that cycle, else rbuf_q[k]; early-granted ports use buffered data and last-granted ports pass live data with zero added latency.
REQ-021 Memory is assumed to return r_valid exactly 1 cycle after its per-port grant.
REQ-022 Back-to-back transactions SHALL be supported: req_i held high after gnt_o starts the next transaction in the following cycle, with no bubble.
REQ-023 In PARTIAL, if req_i falls or any of add_i/wen_i changes vs the value latched at the first grant, err_o SHALL set and stay set until clear_i or reset.
REQ-024 On that error the transaction SHALL be abandoned: done_q <= 0, FSM -> IDLE, no gnt_o and no r_valid_o for it.
REQ-025 stall_cnt_o SHALL increment every cycle with req_i & ~gnt_o and saturate at all-ones.
REQ-026 Simultaneous gnt_o and error condition cannot occur, since gnt_o requires req_i; an add/wen change in the cycle gnt_o fires is NOT an error.

Reset
REQ-027 rst_i = 1 SHALL asynchronously force: done_q = 0, FSM = IDLE, r_valid_o = 0, rbuf_q = 0, err_o = 0, stall_cnt_o = 0, latched add/wen = 0.
REQ-028 Under reset, outputs SHALL be gnt_o = req_i & &tcdm_gnt_i (combinational) and busy_o = 0.
REQ-029 clear_i SHALL have the same effect as rst_i but synchronously, and SHALL take priority over every other update in that cycle.
REQ-030 Reset or clear mid-PARTIAL SHALL drop the transaction silently; any in-flight memory responses after it SHALL be ignored by r_valid_o.

Verification
REQ-031 MP=4, read add_i=0x1000, all tcdm_gnt_i=1111 in cycle 0 -> gnt_o=1 in cycle 0, tcdm_add_o={0x100C,0x1008,0x1004,0x1000}, r_valid_o=1 in cycle 1 with the returned data concatenated.
REQ-032 Staggered grants 0001, 0100, 1010 in cycles 0/1/2 -> tcdm_req_o=1111/1110/1010; gnt_o only in cycle 2; r_valid_o in cycle 3 with ports 0,2 from rbuf_q and ports 1,3 live; stall_cnt_o=2.
REQ-033 Two back-to-back reads, each fully granted -> gnt_o in cycles 0 and 1, r_valid_o in cycles 1 and 2 with the correct data each, no done_q carry-over.
REQ-034 PARTIAL after grant 0011, then req_i dropped -> err_o=1 next cycle, done_q=0, no r_valid_o; clear_i -> err_o=0.
REQ-035 Assert rst_i mid-PARTIAL (done_q=0101) -> done_q=0 and err_o=0 immediately, asynchronously; after release, a fresh request needs all 4 grants.
REQ-036 Hold req_i with tcdm_gnt_i=0 for 70000 cycles (STALL_CW=16) -> stall_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/neureka_tcdm_port_sync_if.sv
// Wide-port / TCDM-port bundle for neureka_tcdm_port_sync.
// The slave side splits one wide access into MP 32-bit memory accesses.
interface neureka_tcdm_port_sync_if #(
    parameter int unsigned MP = 4
);
    logic                  req_i;
    logic [31:0]           add_i;
    logic                  wen_i;
    logic [4*MP-1:0]       be_i;
    logic [32*MP-1:0]      data_i;
    logic                  gnt_o;
    logic                  r_valid_o;
    logic [32*MP-1:0]      r_data_o;
    logic [MP-1:0]         tcdm_req_o;
    logic [MP-1:0][31:0]   tcdm_add_o;
    logic [MP-1:0]         tcdm_wen_o;
    logic [MP-1:0][3:0]    tcdm_be_o;
    logic [MP-1:0][31:0]   tcdm_data_o;
    logic [MP-1:0]         tcdm_gnt_i;
    logic [MP-1:0]         tcdm_r_valid_i;
    logic [MP-1:0][31:0]   tcdm_r_data_i;

    modport slave (
        input  req_i, add_i, wen_i, be_i, data_i,
        output gnt_o, r_valid_o, r_data_o,
        output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
        input  tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_data_i
    );

    modport master (
        output req_i, add_i, wen_i, be_i, data_i,
        input  gnt_o, r_valid_o, r_data_o,
        input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
        output tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_data_i
    );
endinterface

// File: rtl/neureka_tcdm_port_sync.sv
// Splits a wide TCDM access over MP 32-bit ports and grants the wide side only once
// every port has been granted; read data of early ports is buffered until the last one.
module neureka_tcdm_port_sync #(
    parameter int unsigned MP       = 4,
    parameter int unsigned STALL_CW = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    neureka_tcdm_port_sync_if.slave   bus,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [STALL_CW-1:0]       stall_cnt_o
);

    typedef enum logic [0:0] {StIdle, StPartial} state_e;

    state_e                state_q;
    logic [MP-1:0]         done_q;
    logic [MP-1:0]         port_gnt;
    logic [31:0]           add_q;
    logic                  wen_q;
    logic                  r_valid_q;
    logic [MP-1:0][31:0]   rbuf_q;
    logic                  err_q;
    logic [STALL_CW-1:0]   stall_q;
    logic                  gnt;
    logic                  abort;

    always_comb begin
        bus.tcdm_add_o  = '0;
        bus.tcdm_be_o   = '0;
        bus.tcdm_data_o = '0;
        bus.tcdm_wen_o  = '0;
        bus.r_data_o    = '0;
        for (int unsigned k = 0; k < MP; k++) begin
            bus.tcdm_add_o[k]        = bus.add_i + 32'(4 * k);
            bus.tcdm_be_o[k]         = bus.be_i[4*k +: 4];
            bus.tcdm_data_o[k]       = bus.data_i[32*k +: 32];
            bus.tcdm_wen_o[k]        = bus.wen_i;
            // Last-granted ports bypass the buffer so the wide read adds no latency.
            bus.r_data_o[32*k +: 32] = bus.tcdm_r_valid_i[k] ? bus.tcdm_r_data_i[k] : rbuf_q[k];
        end
    end

    assign bus.tcdm_req_o = {MP{bus.req_i}} & ~done_q;
    assign port_gnt       = bus.tcdm_req_o & bus.tcdm_gnt_i;
    assign gnt            = bus.req_i & (&(done_q | bus.tcdm_gnt_i));
    // Master must hold its request stable once any port has been granted.
    assign abort          = (state_q == StPartial) & ~gnt &
                            (~bus.req_i | (bus.add_i != add_q) | (bus.wen_i != wen_q));

    assign bus.gnt_o      = gnt;
    assign bus.r_valid_o  = r_valid_q;
    assign busy_o         = (state_q == StPartial) | r_valid_q;
    assign err_o          = err_q;
    assign stall_cnt_o    = stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            done_q    <= '0;
            add_q     <= '0;
            wen_q     <= 1'b0;
            r_valid_q <= 1'b0;
            rbuf_q    <= '0;
            err_q     <= 1'b0;
            stall_q   <= '0;
        end else if (clear_i) begin
            state_q   <= StIdle;
            done_q    <= '0;
            add_q     <= '0;
            wen_q     <= 1'b0;
            r_valid_q <= 1'b0;
            rbuf_q    <= '0;
            err_q     <= 1'b0;
            stall_q   <= '0;
        end else begin
            r_valid_q <= gnt;
            for (int unsigned k = 0; k < MP; k++) begin
                if (bus.tcdm_r_valid_i[k]) rbuf_q[k] <= bus.tcdm_r_data_i[k];
            end
            if (bus.req_i && !gnt && (stall_q != '1)) stall_q <= stall_q + STALL_CW'(1);
            if (abort) err_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (!gnt && bus.req_i && (|port_gnt)) begin
                        state_q <= StPartial;
                        done_q  <= port_gnt;
                        add_q   <= bus.add_i;
                        wen_q   <= bus.wen_i;
                    end
                end
                StPartial: begin
                    if (gnt || abort) begin
                        state_q <= StIdle;
                        done_q  <= '0;
                    end else begin
                        done_q  <= done_q | port_gnt;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    done_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neureka_tcdm_port_sync.sv
// Directed and randomized checks of neureka_tcdm_port_sync against a transaction-level model
// and a memory that answers each port grant one cycle later.
module tb_neureka_tcdm_port_sync;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        busy;
    logic        err;
    logic [15:0] stall;
    int          checks;
    int          errors;

    // Transaction-level model: ports served so far in the open wide access and its identity.
    logic [3:0]   m_served;
    logic [31:0]  m_add;
    logic         m_wen;
    logic         m_err;
    logic         m_rv;
    logic [127:0] m_rdata;
    logic [15:0]  m_stall;

    neureka_tcdm_port_sync_if #(.MP(4)) bus ();

    neureka_tcdm_port_sync #(.MP(4), .STALL_CW(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .bus         (bus),
        .busy_o      (busy),
        .err_o       (err),
        .stall_cnt_o (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [127:0] wide_data(input logic [31:0] a);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = memf(a + 32'(4 * k));
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        m_served = '0;
        m_add    = '0;
        m_wen    = 1'b0;
        m_err    = 1'b0;
        m_rv     = 1'b0;
        m_rdata  = '0;
        m_stall  = '0;
    endtask

    // One clock cycle: check against the model, advance the model, let memory answer grants.
    task automatic step(input string tag);
        logic [3:0]        e_treq;
        logic              e_gnt;
        logic [127:0]      e_add;
        logic [3:0]        granted;
        logic [3:0][31:0]  gaddr;
        #1;
        e_treq = bus.req_i ? ~m_served : 4'b0;
        e_gnt  = bus.req_i && ((m_served | bus.tcdm_gnt_i) == 4'hF);
        for (int k = 0; k < 4; k++) e_add[32*k +: 32] = bus.add_i + 32'(4 * k);
        check({tag, ".treq"},  128'(bus.tcdm_req_o), 128'(e_treq));
        check({tag, ".gnt"},   128'(bus.gnt_o), 128'(e_gnt));
        check({tag, ".rvld"},  128'(bus.r_valid_o), 128'(m_rv));
        if (m_rv) check({tag, ".rdata"}, bus.r_data_o, m_rdata);
        check({tag, ".busy"},  128'(busy), 128'((m_served != 0) || m_rv));
        check({tag, ".err"},   128'(err), 128'(m_err));
        check({tag, ".stall"}, 128'(stall), 128'(m_stall));
        check({tag, ".tadd"},  128'(bus.tcdm_add_o), e_add);
        check({tag, ".twen"},  128'(bus.tcdm_wen_o), 128'({4{bus.wen_i}}));
        check({tag, ".tbe"},   128'(bus.tcdm_be_o), 128'(bus.be_i));
        check({tag, ".tdata"}, 128'(bus.tcdm_data_o), bus.data_i);
        granted = bus.tcdm_req_o & bus.tcdm_gnt_i;
        gaddr   = bus.tcdm_add_o;
        if (clear) begin
            model_zero();
        end else begin
            m_rv = e_gnt;
            if (e_gnt) m_rdata = wide_data(bus.add_i);
            if (bus.req_i && !e_gnt && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (e_gnt) begin
                m_served = '0;
            end else if (m_served != 0 &&
                         (!bus.req_i || bus.add_i != m_add || bus.wen_i != m_wen)) begin
                m_err    = 1'b1;
                m_served = '0;
            end else if (bus.req_i) begin
                if (m_served == 0 && bus.tcdm_gnt_i != 0) begin
                    m_add = bus.add_i;
                    m_wen = bus.wen_i;
                end
                m_served = m_served | bus.tcdm_gnt_i;
            end
        end
        @(posedge clk);
        #1;
        bus.tcdm_r_valid_i = granted;
        for (int k = 0; k < 4; k++)
            bus.tcdm_r_data_i[k] = granted[k] ? memf(gaddr[k]) : $urandom;
    endtask

    task automatic drive(input logic req, input logic [31:0] add, input logic wen,
                         input logic [3:0] tgnt);
        bus.req_i      = req;
        bus.add_i      = add;
        bus.wen_i      = wen;
        bus.be_i       = 16'($urandom);
        bus.data_i     = {$urandom, $urandom, $urandom, $urandom};
        bus.tcdm_gnt_i = tgnt;
    endtask

    initial begin
        logic [31:0] a;
        logic        w;
        checks = 0;
        errors = 0;
        model_zero();
        rst   = 1'b1;
        clear = 1'b0;
        bus.tcdm_r_valid_i = '0;
        bus.tcdm_r_data_i  = '0;
        drive(1'b1, 32'h0000_1000, 1'b1, 4'hF);

        // Reset: gnt stays combinational, state held at zero across an edge.
        #2;
        check("rst.gnt",   128'(bus.gnt_o), 128'(1));
        check("rst.treq",  128'(bus.tcdm_req_o), 128'(4'hF));
        check("rst.busy",  128'(busy), 128'(0));
        check("rst.err",   128'(err), 128'(0));
        check("rst.stall", 128'(stall), 128'(0));
        @(posedge clk);
        #1;
        check("rst.rvld",  128'(bus.r_valid_o), 128'(0));
        rst = 1'b0;

        // Single-cycle read of all four ports.
        drive(1'b1, 32'h0000_1000, 1'b1, 4'hF);
        #1;
        check("full.tadd", 128'(bus.tcdm_add_o),
              {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1000});
        step("full0");
        drive(1'b0, 32'h0, 1'b0, 4'h0);
        step("full1");

        // Staggered grants 0001, 0100, 1010.
        clear = 1'b1;
        step("clr0");
        clear = 1'b0;
        drive(1'b1, 32'h0000_8000, 1'b1, 4'b0001);
        step("stag0");
        drive(1'b1, 32'h0000_8000, 1'b1, 4'b0100);
        step("stag1");
        drive(1'b1, 32'h0000_8000, 1'b1, 4'b1010);
        #1;
        check("stag2.treq", 128'(bus.tcdm_req_o), 128'(4'b1010));
        step("stag2");
        drive(1'b0, 32'h0, 1'b0, 4'h0);
        check("stag3.stall", 128'(stall), 128'(2));
        step("stag3");

        // Back-to-back fully granted reads.
        drive(1'b1, 32'h0000_2000, 1'b1, 4'hF);
        step("b2b0");
        drive(1'b1, 32'h0000_3000, 1'b1, 4'hF);
        step("b2b1");
        drive(1'b0, 32'h0, 1'b0, 4'h0);
        step("b2b2");

        // Request withdrawn mid-transaction, then soft clear.
        drive(1'b1, 32'h0000_5000, 1'b0, 4'b0011);
        step("drop0");
        drive(1'b0, 32'h0000_5000, 1'b0, 4'b0000);
        step("drop1");
        check("drop2.errset", 128'(err), 128'(1));
        step("drop2");
        clear = 1'b1;
        step("drop3");
        clear = 1'b0;
        check("drop4.errclr", 128'(err), 128'(0));
        step("drop4");

        // Asynchronous reset in the middle of a partial transaction.
        drive(1'b1, 32'h0000_4000, 1'b1, 4'b0101);
        step("arst0");
        drive(1'b1, 32'h0000_4000, 1'b1, 4'b0000);
        #1;
        check("arst.pre", 128'(bus.tcdm_req_o), 128'(4'b1010));
        rst = 1'b1;
        #1;
        check("arst.treq", 128'(bus.tcdm_req_o), 128'(4'hF));
        check("arst.err",  128'(err), 128'(0));
        check("arst.busy", 128'(busy), 128'(0));
        rst = 1'b0;
        model_zero();
        step("arst1");
        drive(1'b1, 32'h0000_4000, 1'b1, 4'hF);
        step("arst2");
        drive(1'b0, 32'h0, 1'b0, 4'h0);
        step("arst3");

        // Randomized transactions with random per-port grants and gaps.
        for (int t = 0; t < 300; t++) begin
            a = $urandom;
            w = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, $urandom, 1'($urandom), 4'($urandom));
                step("rnd.gap");
            end
            drive(1'b1, a, w, 4'($urandom));
            for (int c = 0; c < 40; c++) begin
                bus.tcdm_gnt_i = (c > 20) ? 4'hF : 4'($urandom);
                step("rnd");
                if (m_rv) break;
            end
        end
        drive(1'b0, 32'h0, 1'b0, 4'h0);
        step("rnd.end");

        // Stall counter saturation.
        clear = 1'b1;
        step("sat.clr");
        clear = 1'b0;
        drive(1'b1, 32'h0000_6000, 1'b0, 4'h0);
        repeat (70000) @(posedge clk);
        #1;
        check("sat.stall", 128'(stall), 128'(16'hFFFF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
